// File: rtl/adder_pkg.sv
// Shared constants and parameter checks for the pipelined adder/subtractor.
package adder_pkg;

    localparam logic ADD = 1'b0;
    localparam logic SUB = 1'b1;

    function automatic bit params_ok(int width, int stages);
        return (stages >= 1) && (width >= stages) && ((width % stages) == 0);
    endfunction

    // Falls back to 1 so elaboration can reach the explicit error instead of a width fault.
    function automatic int chunk_width(int width, int stages);
        return params_ok(width, stages) ? (width / stages) : 1;
    endfunction

endpackage

// File: rtl/adder_chunk.sv
// Combinational W-bit add with carry-in; also exposes the carry into the MSB for overflow.
module adder_chunk #(
    parameter int W = 4
) (
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    input  logic         ci,
    output logic [W-1:0] s,
    output logic         co,
    output logic         c_msb
);

    logic [W:0] full;

    assign full  = {1'b0, a} + {1'b0, b} + {{W{1'b0}}, ci};
    assign s     = full[W-1:0];
    assign co    = full[W];
    // Sum bit = a ^ b ^ carry_in, so the carry into the MSB falls out of the sum.
    assign c_msb = a[W-1] ^ b[W-1] ^ full[W-1];

endmodule

// File: rtl/pipelined_adder_n.sv
// Pipelined WIDTH-bit adder/subtractor: one carry chunk per stage, skew/de-skew registers,
// and a single global advance enable driven by the output handshake.
module pipelined_adder_n
    import adder_pkg::*;
#(
    parameter int WIDTH  = 16,
    parameter int STAGES = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    input  logic             sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             ovf,
    output logic             busy
);

    localparam int CHUNK = chunk_width(WIDTH, STAGES);

    if (!params_ok(WIDTH, STAGES)) begin : g_param_check
        $error("pipelined_adder_n: WIDTH must be a positive multiple of STAGES");
    end

    // a_q/b_q hold the not-yet-added operand bits shifted down so the next chunk sits at bit 0;
    // s_q accumulates the finished low chunks in place.
    logic [WIDTH-1:0]  a_q [STAGES];
    logic [WIDTH-1:0]  a_d [STAGES];
    logic [WIDTH-1:0]  b_q [STAGES];
    logic [WIDTH-1:0]  b_d [STAGES];
    logic [WIDTH-1:0]  s_q [STAGES];
    logic [WIDTH-1:0]  s_d [STAGES];
    logic [STAGES-1:0] c_q, c_d;
    logic [STAGES-1:0] v_q, v_d;
    logic              ovf_q, ovf_d;

    logic [WIDTH-1:0]  st_a [STAGES];
    logic [WIDTH-1:0]  st_b [STAGES];
    logic [WIDTH-1:0]  st_s [STAGES];
    logic [STAGES-1:0] st_c;
    logic [CHUNK-1:0]  ch_sum [STAGES];
    logic [STAGES-1:0] ch_co;
    logic [STAGES-1:0] ch_cmsb;
    logic              adv;

    always_comb begin
        st_c = '0;
        for (int k = 0; k < STAGES; k++) begin
            st_a[k] = '0;
            st_b[k] = '0;
            st_s[k] = '0;
        end
        st_a[0] = a;
        st_b[0] = (sub == SUB) ? ~b : b;
        st_c[0] = cin ^ sub;
        for (int k = 1; k < STAGES; k++) begin
            st_a[k] = a_q[k-1];
            st_b[k] = b_q[k-1];
            st_c[k] = c_q[k-1];
            st_s[k] = s_q[k-1];
        end
    end

    for (genvar k = 0; k < STAGES; k++) begin : g_chunk
        adder_chunk #(.W(CHUNK)) u_chunk (
            .a     (st_a[k][CHUNK-1:0]),
            .b     (st_b[k][CHUNK-1:0]),
            .ci    (st_c[k]),
            .s     (ch_sum[k]),
            .co    (ch_co[k]),
            .c_msb (ch_cmsb[k])
        );
    end

    always_comb begin
        adv   = out_ready || !v_q[STAGES-1];
        a_d   = a_q;
        b_d   = b_q;
        s_d   = s_q;
        c_d   = c_q;
        v_d   = v_q;
        ovf_d = ovf_q;
        if (adv) begin
            for (int k = 0; k < STAGES; k++) begin
                a_d[k] = st_a[k] >> CHUNK;
                b_d[k] = st_b[k] >> CHUNK;
                s_d[k] = st_s[k] | (WIDTH'(ch_sum[k]) << (k * CHUNK));
                c_d[k] = ch_co[k];
            end
            v_d[0] = in_valid;
            for (int k = 1; k < STAGES; k++) begin
                v_d[k] = v_q[k-1];
            end
            ovf_d = ch_cmsb[STAGES-1] ^ ch_co[STAGES-1];
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int k = 0; k < STAGES; k++) begin
                a_q[k] <= '0;
                b_q[k] <= '0;
                s_q[k] <= '0;
            end
            c_q   <= '0;
            v_q   <= '0;
            ovf_q <= 1'b0;
        end else begin
            a_q   <= a_d;
            b_q   <= b_d;
            s_q   <= s_d;
            c_q   <= c_d;
            v_q   <= v_d;
            ovf_q <= ovf_d;
        end
    end

    assign in_ready  = adv;
    assign out_valid = v_q[STAGES-1];
    assign sum       = s_q[STAGES-1];
    assign cout      = c_q[STAGES-1];
    assign ovf       = ovf_q;
    assign busy      = |v_q;

endmodule

// File: tb/tb_pipelined_adder_n.sv
// Directed bench for pipelined_adder_n (WIDTH=16, STAGES=4) with an expected-result queue.
module tb_pipelined_adder_n;

    localparam int W = 16;
    localparam int S = 4;

    logic         clk = 1'b0;
    logic         rst;
    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         cin;
    logic         sub;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] sum;
    logic         cout;
    logic         ovf;
    logic         busy;

    pipelined_adder_n #(.WIDTH(W), .STAGES(S)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .cin       (cin),
        .sub       (sub),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .sum       (sum),
        .cout      (cout),
        .ovf       (ovf),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [W-1:0] sum;
        logic         cout;
        logic         ovf;
    } res_t;

    res_t exp_q[$];
    res_t cur_exp;
    int   n_vec     = 0;
    int   n_mis     = 0;
    int   run_len   = 0;
    bit   prev_emit = 1'b0;

    function automatic res_t model(logic [W-1:0] ma, logic [W-1:0] mb, logic mc, logic ms);
        logic [W-1:0] bp;
        logic [W:0]   full;
        res_t         r;
        bp     = ms ? ~mb : mb;
        full   = {1'b0, ma} + {1'b0, bp} + {{W{1'b0}}, mc ^ ms};
        r.sum  = full[W-1:0];
        r.cout = full[W];
        r.ovf  = (ma[W-1] == bp[W-1]) && (full[W-1] != ma[W-1]);
        return r;
    endfunction

    function automatic res_t mk(logic [W-1:0] s, logic c, logic o);
        return {s, c, o};
    endfunction

    task automatic check(string tag, logic [31:0] obs, logic [31:0] expv);
        n_vec++;
        assert (obs === expv) else begin
            n_mis++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, expv);
        end
    endtask

    // Called at a falling edge with inputs already set; returns at the next falling edge.
    task automatic tick(output bit acc);
        bit   emit;
        res_t got;
        res_t e;
        #1;
        acc  = in_valid && in_ready;
        emit = out_valid && out_ready;
        got  = {sum, cout, ovf};
        @(posedge clk);
        if (emit) begin
            run_len = prev_emit ? run_len + 1 : 1;
            if (exp_q.size() == 0) begin
                check("unexpected_beat", 32'd1, 32'd0);
            end else begin
                e = exp_q.pop_front();
                check("sum", 32'(got.sum), 32'(e.sum));
                check("cout", 32'(got.cout), 32'(e.cout));
                check("ovf", 32'(got.ovf), 32'(e.ovf));
            end
        end
        if (acc) exp_q.push_back(cur_exp);
        prev_emit = emit;
        @(negedge clk);
    endtask

    task automatic send(logic [W-1:0] va, logic [W-1:0] vb, logic vc, logic vs, res_t e);
        bit acc;
        int n;
        a        = va;
        b        = vb;
        cin      = vc;
        sub      = vs;
        in_valid = 1'b1;
        cur_exp  = e;
        acc      = 1'b0;
        n        = 0;
        while (!acc && n < 20) begin
            tick(acc);
            n++;
        end
        in_valid = 1'b0;
        if (!acc) check("accept_timeout", 32'd0, 32'd1);
    endtask

    task automatic drain();
        bit acc;
        int n;
        n        = 0;
        in_valid = 1'b0;
        while (exp_q.size() != 0 && n < 50) begin
            tick(acc);
            n++;
        end
        check("drain_empty", 32'(exp_q.size()), 32'd0);
    endtask

    task automatic check_latency(string tag);
        bit acc;
        int lat;
        lat = 0;
        while (!out_valid && lat < 10) begin
            tick(acc);
            lat++;
        end
        check(tag, 32'(lat), 32'(S - 1));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "simulation time limit reached");
    end

    initial begin
        bit           acc;
        logic [W-1:0] va, vb;
        logic         vc, vs;
        logic [31:0]  hold;

        rst       = 1'b1;
        in_valid  = 1'b0;
        a         = '0;
        b         = '0;
        cin       = 1'b0;
        sub       = 1'b0;
        out_ready = 1'b0;
        #12;
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_sum", 32'(sum), 32'd0);
        check("rst_cout", 32'(cout), 32'd0);
        check("rst_ovf", 32'(ovf), 32'd0);
        check("rst_in_ready", 32'(in_ready), 32'd1);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        out_ready = 1'b1;

        // Basic add with latency measurement
        send(16'h00FF, 16'h0001, 1'b0, 1'b0, mk(16'h0100, 1'b0, 1'b0));
        check_latency("t1_latency");
        drain();

        // Full ripple and signed overflow
        send(16'hFFFF, 16'h0001, 1'b0, 1'b0, mk(16'h0000, 1'b1, 1'b0));
        send(16'h7FFF, 16'h0001, 1'b0, 1'b0, mk(16'h8000, 1'b0, 1'b1));
        drain();

        // Subtract, with and without borrow
        send(16'h7FFF, 16'hFFFF, 1'b0, 1'b1, mk(16'h8000, 1'b0, 1'b1));
        send(16'h0005, 16'h0003, 1'b1, 1'b1, mk(16'h0001, 1'b1, 1'b0));
        drain();

        // Back-to-back stream
        for (int i = 0; i < 8; i++) begin
            send(16'(i), 16'(32'h1000 * i), 1'b0, 1'b0, mk(16'(32'h1001 * i), 1'b0, 1'b0));
        end
        drain();
        check("b2b_run", 32'(run_len), 32'd8);

        // Backpressure mid-stream
        for (int i = 0; i < 6; i++) begin
            va = 16'($urandom);
            vb = 16'($urandom);
            vc = 1'($urandom_range(0, 1));
            vs = 1'($urandom_range(0, 1));
            if (i == 4) begin
                a         = va;
                b         = vb;
                cin       = vc;
                sub       = vs;
                in_valid  = 1'b1;
                cur_exp   = model(va, vb, vc, vs);
                out_ready = 1'b0;
                #1;
                hold = 32'({sum, cout, ovf});
                check("stall_in_ready0", 32'(in_ready), 32'd0);
                @(negedge clk);
                for (int j = 0; j < 3; j++) begin
                    tick(acc);
                    check("stall_accept", 32'(acc), 32'd0);
                    check("stall_in_ready", 32'(in_ready), 32'd0);
                    check("stall_valid", 32'(out_valid), 32'd1);
                    check("stall_hold", 32'({sum, cout, ovf}), hold);
                end
                out_ready = 1'b1;
            end
            send(va, vb, vc, vs, model(va, vb, vc, vs));
        end
        drain();

        // Reset with beats in flight
        for (int i = 0; i < 3; i++) begin
            va = 16'($urandom);
            vb = 16'($urandom);
            send(va, vb, 1'b0, 1'b0, model(va, vb, 1'b0, 1'b0));
        end
        tick(acc);
        check("pre_rst_valid", 32'(out_valid), 32'd1);
        rst = 1'b1;
        #1;
        check("rst_mid_out_valid", 32'(out_valid), 32'd0);
        check("rst_mid_busy", 32'(busy), 32'd0);
        exp_q.delete();
        prev_emit = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        for (int j = 0; j < 6; j++) begin
            tick(acc);
            check("post_rst_idle", 32'(out_valid), 32'd0);
        end
        send(16'h1234, 16'h1111, 1'b0, 1'b0, mk(16'h2345, 1'b0, 1'b0));
        check_latency("t6_latency");
        drain();
        check("final_busy", 32'(busy), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_mis);
        $finish;
    end

endmodule

// File: doc/pipelined_adder_n.md
# pipelined_adder_n

Parametrised, pipelined N-bit adder/subtractor: successor to the fixed 4-bit ripple adder in the RTL-to-GDS flow. Carry is split into STAGES chunks with one register per chunk, so timing closes at wide WIDTH. Operands enter and results leave through valid/ready handshakes, so the block sits directly in a streaming datapath. Supports add/subtract mode, carry-in, carry-out and signed overflow.

## Interface
- WIDTH, 16: operand/result width in bits; must be a multiple of STAGES.
- STAGES, 4: number of pipeline stages/carry chunks, ≥1. CHUNK = WIDTH/STAGES.
- clk  in  1  single clock, rising edge.
- rst  in  1  reset, asynchronous, active-high.
- in_valid  in  1  operand beat valid.
- in_ready  out  1  block accepts a beat this cycle.
- a  in  WIDTH  operand A.
- b  in  WIDTH  operand B.
- cin  in  1  carry-in (borrow modifier in subtract mode).
- sub  in  1  0 = add, 1 = subtract.
- out_valid  out  1  result beat valid.
- out_ready  in  1  downstream accepts result.
- sum  out  WIDTH  result.
- cout  out  1  raw carry out of MSB.
- ovf  out  1  signed two's-complement overflow.
- busy  out  1  any stage holds a valid beat.

## Operation
- Effective operand: b' = sub ? ~b : b; effective carry-in c0 = cin ^ sub. Add gives a+b+cin; subtract gives a−b−cin.
- sum = (a + b' + c0) mod 2^WIDTH. cout is bit WIDTH of the full-width sum.
- ovf = (a[MSB] == b'[MSB]) && (sum[MSB] != a[MSB]).
- Stage k (0..STAGES−1) computes chunk k (bits k·CHUNK .. k·CHUNK+CHUNK−1) from the registered carry of stage k−1. Stage 0 uses c0.
- Unprocessed upper chunks of a and b' are carried forward in skew registers. Completed lower sum chunks are carried forward in de-skew registers. All chunks of one beat leave together.
- Each stage has a valid bit. Global advance enable: adv = out_ready || !out_valid.
- in_ready = adv. A beat is accepted when in_valid && in_ready.
- When adv = 1, every stage register loads from its predecessor. Stage 0 valid loads in_valid && in_ready.
- When adv = 0, all stage registers, including valid bits, hold.
- Results emerge in acceptance order. No beat is dropped or duplicated.
- busy = OR of all stage valid bits.
- STAGES = 1 degenerates to a single registered full-width adder with latency 1.

## Timing
- Reset (async assert, synchronous release): all valid bits 0, out_valid 0, sum 0, cout 0, ovf 0, busy 0.
  - in_ready is combinationally 1 once out_valid = 0.
- Latency: a beat accepted at edge t has out_valid = 1 after edge t+STAGES−1. It is presented for one cycle if out_ready = 1.
- Throughput: one beat per cycle while out_ready stays 1.
- Output stability: while out_valid && !out_ready, sum/cout/ovf/out_valid hold constant.
- in_ready depends combinationally on out_ready; there is no other combinational input-to-output path.
- Empty pipeline with out_ready = 0: in_ready = 1 because out_valid = 0, so bubbles fill until the output stage is valid.
- Simultaneous accept and emit in one cycle is legal. Occupancy is unchanged.
- Reset mid-stream: all in-flight beats are discarded. No out_valid is seen until fresh beats traverse the full latency.
- sub and cin are sampled with a, b at acceptance; later changes do not affect in-flight beats.

## Structure
- Shared package `adder_pkg`:
  - mode constants ADD = 1'b0, SUB = 1'b1.
  - function for the CHUNK width check; elaboration errors if WIDTH % STAGES != 0 or STAGES < 1.
- Sub-module `adder_chunk`:
  - purely combinational CHUNK-bit add with carry-in.
  - outputs carry-out, plus MSB carry-in (used for ovf in the top chunk).
  - instantiated STAGES times via generate.
- Top module holds stage registers, skew/de-skew arrays, valid chain, and handshake logic.

## Test plan
All scenarios use WIDTH = 16, STAGES = 4.
1. Reset, then a=0x00FF, b=0x0001, cin=0, sub=0, out_ready=1: out_valid 3 cycles after the accept edge, sum=0x0100, cout=0, ovf=0.
2. Full carry ripple: a=0xFFFF, b=0x0001, cin=0, sub=0 -> sum=0x0000, cout=1, ovf=0. Then a=0x7FFF, b=0x0001 -> sum=0x8000, cout=0, ovf=1.
3. Subtract: a=0x7FFF, b=0xFFFF, sub=1, cin=0 -> sum=0x8000, ovf=1. Then a=0x0005, b=0x0003, sub=1, cin=1 -> sum=0x0001, cout=1, ovf=0.
4. Back-to-back: 8 consecutive beats (a=i, b=0x1000·i, i=0..7), out_ready=1 -> 8 consecutive out_valid cycles, sums 0x1001·i, in order.
5. Backpressure: stream 6 beats, drop out_ready for 3 cycles mid-stream.
   - in_ready = 0 while the output is stalled; the output beat holds stable.
   - All 6 results are delivered in order with no duplicates; a scoreboard against a reference model passes.
6. Reset mid-operation: assert rst with 3 beats in flight -> out_valid and busy drop immediately (async). After release, no stale result appears; a new beat 0x1234+0x1111 yields 0x2345 at the normal latency.
